inert_intf: RTL

INERT_INTF -- requirements
Module: inert_intf

---
 rtl/inert_intf.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/inert_intf.sv
// Mode-3 SPI master and sequencer: configures the inertial sensor, then reads pitch rate and Z accel on each INT.
// vld fires on the clk SS_n rises after the fourth read; no backpressure, results overwrite in place.
module inert_intf #(
  parameter int INIT_W   = 16,
  parameter int SCLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int PH_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PH_W-1:0] HALF_LAST = PH_W'(HALF - 1);

  typedef enum logic [2:0] {
    INIT_WAIT, WR_CTRL1, WR_CTRL2, WAIT_INT, RD_PL, RD_PH, RD_AL, RD_AH
  } state_t;

  state_t state_q, state_nxt;

  logic              int_s1, int_s2;
  logic [INIT_W-1:0] init_cnt;
  logic              issued;
  logic              start;
  logic              frame_state;
  logic [15:0]       cmd;

  logic              busy;
  logic [PH_W-1:0]   half_cnt;
  logic [5:0]        half_idx;
  logic [PH_W-1:0]   gap_cnt;
  logic [14:0]       tx;
  logic [7:0]        rx;
  logic              ready;
  logic              frame_end;

  logic [7:0]        pl_b, ph_b, al_b;

  // Half-period 0 is the front porch; odd halves are SCLK low, even halves SCLK high.
  assign ready     = !busy && (gap_cnt == HALF_LAST);
  assign frame_end = busy && (half_cnt == HALF_LAST) && (half_idx == 6'd32);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      half_cnt <= '0;
      half_idx <= '0;
      gap_cnt  <= HALF_LAST;
      tx       <= '0;
      rx       <= '0;
      SS_n     <= 1'b1;
      SCLK     <= 1'b1;
      MOSI     <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      half_cnt <= '0;
      half_idx <= '0;
      tx       <= cmd[14:0];
      SS_n     <= 1'b0;
      SCLK     <= 1'b1;
      MOSI     <= cmd[15];
    end else if (busy) begin
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        if (half_idx == 6'd32) begin
          busy    <= 1'b0;
          SS_n    <= 1'b1;
          SCLK    <= 1'b1;
          gap_cnt <= '0;
        end else begin
          half_idx <= half_idx + 6'd1;
          if (!half_idx[0]) begin
            SCLK <= 1'b0;
            // cmd[15] is already on MOSI from the porch, so the first fall does not shift.
            if (half_idx != 6'd0) begin
              MOSI <= tx[14];
              tx   <= {tx[13:0], 1'b0};
            end
          end else begin
            SCLK <= 1'b1;
            rx   <= {rx[6:0], MISO};
          end
        end
      end else begin
        half_cnt <= half_cnt + PH_W'(1);
      end
    end else if (gap_cnt != HALF_LAST) begin
      gap_cnt <= gap_cnt + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_WAIT;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      INIT_WAIT: if (&init_cnt) state_nxt = WR_CTRL1;
      WR_CTRL1:  if (frame_end) state_nxt = WR_CTRL2;
      WR_CTRL2:  if (frame_end) state_nxt = WAIT_INT;
      WAIT_INT:  if (int_s2)    state_nxt = RD_PL;
      RD_PL:     if (frame_end) state_nxt = RD_PH;
      RD_PH:     if (frame_end) state_nxt = RD_AL;
      RD_AL:     if (frame_end) state_nxt = RD_AH;
      RD_AH:     if (frame_end) state_nxt = WAIT_INT;
      default:   state_nxt = INIT_WAIT;
    endcase
  end

  always_comb begin
    cmd         = 16'h0000;
    frame_state = 1'b1;
    case (state_q)
      WR_CTRL1: cmd = 16'h0D02;
      WR_CTRL2: cmd = 16'h1150;
      RD_PL:    cmd = 16'hA200;
      RD_PH:    cmd = 16'hA300;
      RD_AL:    cmd = 16'hAC00;
      RD_AH:    cmd = 16'hAD00;
      default:  frame_state = 1'b0;
    endcase
    start = frame_state && !issued && ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_s1   <= 1'b0;
      int_s2   <= 1'b0;
      init_cnt <= '0;
      issued   <= 1'b0;
      pl_b     <= '0;
      ph_b     <= '0;
      al_b     <= '0;
      ptch_rt  <= '0;
      AZ       <= '0;
      vld      <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
      vld    <= 1'b0;
      if (state_q == INIT_WAIT) init_cnt <= init_cnt + INIT_W'(1);
      if (start) begin
        issued <= 1'b1;
      end else if (frame_end) begin
        issued <= 1'b0;
      end
      // Both words load together from the held bytes so no half-updated value is ever visible.
      if (frame_end) begin
        case (state_q)
          RD_PL: pl_b <= rx;
          RD_PH: ph_b <= rx;
          RD_AL: al_b <= rx;
          RD_AH: begin
            ptch_rt <= {ph_b, pl_b};
            AZ      <= {rx, al_b};
            vld     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
